// File: rtl/rf_issue_stage_pkg.sv
// Shared definitions for the register-file issue stage: register count, address
// width, source-select encodings and the per-lane uop view of the issue bundle.
package rf_issue_stage_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  typedef enum logic {
    SEL_RF  = 1'b0,
    SEL_ALT = 1'b1
  } src_sel_e;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] rd;
    logic [AW-1:0] rj;
    logic [AW-1:0] rk;
    logic          is_long;
    src_sel_e      sel1;
    src_sel_e      sel2;
  } uop_t;

  function automatic logic nz(input logic [AW-1:0] a);
    return a != '0;
  endfunction

endpackage

// File: rtl/rf_issue_stage_bypass.sv
// rf_bypass_read: one source operand read with same-cycle write-back bypass.
// Highest-index matching write port wins; r0 always reads zero.
module rf_bypass_read
  import rf_issue_stage_pkg::*;
#(
  parameter int WPORTS = 2,
  parameter int XLEN   = 32
) (
  input  logic [AW-1:0]          addr_i,
  input  logic [XLEN-1:0]        arr_i,
  input  logic [WPORTS-1:0]      wb_en_i,
  input  logic [WPORTS*AW-1:0]   wb_addr_i,
  input  logic [WPORTS*XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0]        data_o
);

  always_comb begin
    data_o = arr_i;
    for (int unsigned p = 0; p < WPORTS; p++) begin
      if (wb_en_i[p] && (wb_addr_i[p*AW +: AW] == addr_i)) begin
        data_o = wb_data_i[p*XLEN +: XLEN];
      end
    end
    if (addr_i == '0) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/rf_issue_stage.sv
// Register-file read / issue stage with write-back bypass and one output register.
// RF_SCOREBOARD_EN selects the pending-register scoreboard; otherwise hazards are
// detected against long-latency ops sitting in the output register.
module rf_issue_stage
  import rf_issue_stage_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int WPORTS    = 2,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [WPORTS-1:0]          wb_en,
  input  logic [WPORTS*AW-1:0]       wb_addr,
  input  logic [WPORTS*XLEN-1:0]     wb_data,
  input  logic [WPORTS-1:0]          wb_clr,
  input  logic [LANES-1:0]           in_en,
  input  logic [LANES*AW-1:0]        in_rd,
  input  logic [LANES*AW-1:0]        in_rj,
  input  logic [LANES*AW-1:0]        in_rk,
  input  logic [LANES-1:0]           in_long,
  input  logic [LANES-1:0]           in_sel1,
  input  logic [LANES-1:0]           in_sel2,
  input  logic [LANES*XLEN-1:0]      in_alt1,
  input  logic [LANES*XLEN-1:0]      in_alt2,
  input  logic [LANES*PAYLOAD_W-1:0] in_payload,
  output logic [LANES-1:0]           out_en,
  output logic [LANES*AW-1:0]        out_rd,
  output logic [LANES*PAYLOAD_W-1:0] out_payload,
  output logic [LANES*XLEN-1:0]      out_src1,
  output logic [LANES*XLEN-1:0]      out_src2,
  output logic                       stall_req
);

  logic [XLEN-1:0]          rf_q [NREGS];
  uop_t                     uop [LANES];
  logic [XLEN-1:0]          rj_val [LANES];
  logic [XLEN-1:0]          rk_val [LANES];
  logic [XLEN-1:0]          src1_d [LANES];
  logic [XLEN-1:0]          src2_d [LANES];
  logic [LANES-1:0]         out_en_q;
  logic [LANES*AW-1:0]      out_rd_q;
  logic [LANES*XLEN-1:0]    src1_q;
  logic [LANES*XLEN-1:0]    src2_q;
  logic [LANES*PAYLOAD_W-1:0] payload_q;
  logic                     hazard;

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      uop[l].en      = in_en[l];
      uop[l].rd      = in_rd[l*AW +: AW];
      uop[l].rj      = in_rj[l*AW +: AW];
      uop[l].rk      = in_rk[l*AW +: AW];
      uop[l].is_long = in_long[l];
      uop[l].sel1    = src_sel_e'(in_sel1[l]);
      uop[l].sel2    = src_sel_e'(in_sel2[l]);
    end
  end

  // Writes land every edge regardless of stall/flush; later ports override earlier ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < WPORTS; p++) begin
        if (wb_en[p] && nz(wb_addr[p*AW +: AW])) begin
          rf_q[wb_addr[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rf_bypass_read #(.WPORTS(WPORTS), .XLEN(XLEN)) u_rd_j (
      .addr_i    (in_rj[g*AW +: AW]),
      .arr_i     (rf_q[in_rj[g*AW +: AW]]),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .data_o    (rj_val[g])
    );
    rf_bypass_read #(.WPORTS(WPORTS), .XLEN(XLEN)) u_rd_k (
      .addr_i    (in_rk[g*AW +: AW]),
      .arr_i     (rf_q[in_rk[g*AW +: AW]]),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .data_o    (rk_val[g])
    );
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      src1_d[l] = (uop[l].sel1 == SEL_ALT) ? in_alt1[l*XLEN +: XLEN] : rj_val[l];
      src2_d[l] = (uop[l].sel2 == SEL_ALT) ? in_alt2[l*XLEN +: XLEN] : rk_val[l];
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREGS-1:0] sb_q, sb_d, clr_mask, set_mask, pend;
  logic             accept;

  always_comb begin
    clr_mask = '0;
    for (int unsigned p = 0; p < WPORTS; p++) begin
      if (wb_en[p] && wb_clr[p]) begin
        clr_mask[wb_addr[p*AW +: AW]] = 1'b1;
      end
    end
    pend = sb_q & ~clr_mask;
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (uop[l].en) begin
        if (uop[l].sel1 == SEL_RF && nz(uop[l].rj) && pend[uop[l].rj]) hazard = 1'b1;
        if (uop[l].sel2 == SEL_RF && nz(uop[l].rk) && pend[uop[l].rk]) hazard = 1'b1;
      end
    end
  end

  assign stall_req = hazard;
  assign accept    = !stall && !stall_req && !flush;

  // Set is OR-ed after the clear so a same-cycle set of the same register wins.
  always_comb begin
    set_mask = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (accept && uop[l].en && uop[l].is_long && nz(uop[l].rd)) begin
        set_mask[uop[l].rd] = 1'b1;
      end
    end
    sb_d = flush ? '0 : ((sb_q & ~clr_mask) | set_mask);
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sb_q <= '0;
    else       sb_q <= sb_d;
  end
`else
  logic [LANES-1:0] out_long_q;
  logic             hz_seen_q, hz_seen_d;
  logic             unused_wb_clr;

  assign unused_wb_clr = ^wb_clr;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (uop[l].en) begin
        for (int unsigned o = 0; o < LANES; o++) begin
          if (out_en_q[o] && out_long_q[o]) begin
            if (uop[l].sel1 == SEL_RF && nz(uop[l].rj) && uop[l].rj == out_rd_q[o*AW +: AW])
              hazard = 1'b1;
            if (uop[l].sel2 == SEL_RF && nz(uop[l].rk) && uop[l].rk == out_rd_q[o*AW +: AW])
              hazard = 1'b1;
          end
        end
      end
    end
  end

  // A held hazard is reported for one stalled cycle only.
  assign stall_req = hazard && !hz_seen_q;

  always_comb begin
    hz_seen_d = hz_seen_q;
    if (flush || !stall) hz_seen_d = 1'b0;
    else if (stall_req)  hz_seen_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hz_seen_q  <= 1'b0;
      out_long_q <= '0;
    end else begin
      hz_seen_q <= hz_seen_d;
      if (!flush && !stall) out_long_q <= in_long;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_en_q  <= '0;
      out_rd_q  <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      payload_q <= '0;
    end else if (flush) begin
      out_en_q <= '0;
    end else if (!stall) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        out_en_q[l]                     <= in_en[l] & ~stall_req;
        out_rd_q[l*AW +: AW]            <= in_rd[l*AW +: AW];
        src1_q[l*XLEN +: XLEN]          <= src1_d[l];
        src2_q[l*XLEN +: XLEN]          <= src2_d[l];
        payload_q[l*PAYLOAD_W +: PAYLOAD_W] <= in_payload[l*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign out_en      = out_en_q;
  assign out_rd      = out_rd_q;
  assign out_src1    = src1_q;
  assign out_src2    = src2_q;
  assign out_payload = payload_q;

endmodule
